fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: i_clk  input  1  rising-edge clock; i_reset_n  input  1  asynchronous active-low reset.
REQ-002 Parameter RESET_VECTOR, default 16'h0000, first instruction address fetched after reset.
REQ-003 o_imem_addr  output  16  word address to synchronous instruction memory (data returns next cycle).
REQ-004 i_imem_data  input  16  instruction word for the address presented on the previous cycle.
REQ-005 i_stall  input  1  pipeline stall from stall control (decode-stage hazard).
REQ-006 i_branch_taken  input  1  redirect request from execute stage.
REQ-007 i_branch_target  input  16  redirect word address.
REQ-008 o_decode_valid  output  1  IF/ID register holds a correct-path instruction.
REQ-009 o_decode_pc  output  16  word address of the instruction in IF/ID.
REQ-010 o_decode_instruction  output  16  instruction word in IF/ID.
REQ-011 o_stall_count  output  16  saturating count of stall-hold cycles.
REQ-012 o_flush_count  output  16  saturating count of branch redirects.

Function
REQ-013 Internal r_pc (16b) SHALL hold the address whose data is on i_imem_data this cycle; r_fetch_valid SHALL mark that data as meaningful.
REQ-014 Next address (combinational, driven on o_imem_addr) SHALL be: i_branch_taken -> i_branch_target; else (!r_fetch_valid or i_stall) -> r_pc; else r_pc+1.
REQ-015 On every clock r_pc SHALL load the next address and r_fetch_valid SHALL load 1.
REQ-016 PC increment SHALL be modulo 2^16 (16'hFFFF+1 = 16'h0000).
REQ-017 IF/ID update priority: i_branch_taken -> o_decode_valid<=0, pc/instruction held; else i_stall -> all IF/ID outputs held; else o_decode_valid<=r_fetch_valid, o_decode_pc<=r_pc, o_decode_instruction<=i_imem_data.
REQ-018 Branch SHALL override a simultaneous stall (stalled decode instruction is wrong-path and is squashed).
REQ-019 During stall o_imem_addr SHALL equal r_pc so i_imem_data stays stable for the held instruction.
REQ-020 Redirect latency: target instruction SHALL appear on o_decode_pc/o_decode_valid=1 two clocks after the i_branch_taken cycle, absent stall.
REQ-021 i_stall SHALL be honoured regardless of o_decode_valid.
REQ-022 o_stall_count SHALL increment on cycles with i_stall=1 and i_branch_taken=0; o_flush_count SHALL increment on cycles with i_branch_taken=1; both SHALL saturate at 16'hFFFF.

Reset
REQ-023 While i_reset_n=0: r_pc=RESET_VECTOR, r_fetch_valid=0, o_decode_valid=0, o_decode_pc=0, o_decode_instruction=0, counters=0; o_imem_addr=RESET_VECTOR.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight fetches immediately, without waiting for a clock edge.
REQ-025 First cycle after reset release SHALL re-present RESET_VECTOR; first valid decode SHALL appear two clocks after release.

Structure
REQ-026 Shared package SHALL hold address width (16), instruction width (16), and the default RESET_VECTOR constant; register-selector width (4) stays with stall control.
REQ-027 One sub-module SHALL exist: sat_counter (16b, increment enable, async active-low reset), instantiated twice.
REQ-028 No other state machine beyond r_fetch_valid; all outputs except o_imem_addr SHALL be registered.

Verification
REQ-029 Reset release, memory returns mem[a]=16'hA000+a, no stall/branch -> o_decode_pc 0,1,2,... with matching instructions; first valid 2 clocks after release.
REQ-030 Stall 3 cycles while o_decode_pc=5 -> decode outputs hold at pc 5, o_imem_addr holds 6, o_stall_count=3, then pc 6 follows with no skip or duplicate.
REQ-031 Branch to 16'h0040 while o_decode_pc=8 -> next o_decode_valid=0, then pc 16'h0040 valid, o_flush_count=1.
REQ-032 i_stall=1 and i_branch_taken=1 same cycle, target 16'h0100 -> squash wins, o_stall_count unchanged, pc 16'h0100 valid two clocks later.
REQ-033 RESET_VECTOR=16'hFFFE, free-run -> decode pc FFFE, FFFF, 0000, 0001.
REQ-034 Assert i_reset_n mid-stream without a clock edge -> o_decode_valid drops to 0 immediately; preload counters near 16'hFFFF -> saturate, no wrap.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//   ADDR_W / INSTR_W      : word-address and instruction widths
//   DEFAULT_RESET_VECTOR  : address fetched first after reset
package fetch_stage_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam addr_t DEFAULT_RESET_VECTOR = 16'h0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline event statistics.
//   i_clk      : rising-edge clock
//   i_reset_n  : asynchronous active-low reset, clears the count
//   i_inc      : count this cycle
//   o_count    : current count, sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_count <= '0;
    end else if (i_inc && (o_count != '1)) begin
      o_count <= o_count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
//   i_clk, i_reset_n      : clock, asynchronous active-low reset
//   o_imem_addr           : word address to synchronous instruction memory
//   i_imem_data           : instruction for the address of the previous cycle
//   i_stall               : hold fetch and IF/ID (decode hazard)
//   i_branch_taken/target : redirect from execute, squashes IF/ID
//   o_decode_valid/pc/instruction : IF/ID register contents
//   o_stall_count, o_flush_count  : saturating event counters
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter addr_t RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic [INSTR_W-1:0] i_imem_data,
  input  logic               i_stall,
  input  logic               i_branch_taken,
  input  logic [ADDR_W-1:0]  i_branch_target,
  output logic               o_decode_valid,
  output logic [ADDR_W-1:0]  o_decode_pc,
  output logic [INSTR_W-1:0] o_decode_instruction,
  output logic [15:0]        o_stall_count,
  output logic [15:0]        o_flush_count
);

  // r_pc is the address whose data is on i_imem_data this cycle;
  // r_fetch_valid is low only for the first cycle after reset.
  addr_t r_pc;
  logic  r_fetch_valid;
  addr_t next_pc;

  // NOTE: every branch of this combinational block assigns next_pc (default
  // first), so no latch is inferred.
  always_comb begin
    next_pc = r_pc + 1'b1;  // wraps modulo 2^16
    if (!i_reset_n) begin
      next_pc = RESET_VECTOR;
    end else if (i_branch_taken) begin
      next_pc = i_branch_target;
    end else if (!r_fetch_valid || i_stall) begin
      // Re-present the same address so memory data stays stable.
      next_pc = r_pc;
    end
  end

  assign o_imem_addr = next_pc;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc          <= RESET_VECTOR;
      r_fetch_valid <= 1'b0;
    end else begin
      r_pc          <= next_pc;
      r_fetch_valid <= 1'b1;
    end
  end

  // IF/ID register: a branch squashes (even over a stall, since the stalled
  // instruction is wrong-path); a stall holds everything.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_decode_valid       <= 1'b0;
      o_decode_pc          <= '0;
      o_decode_instruction <= '0;
    end else if (i_branch_taken) begin
      o_decode_valid <= 1'b0;
    end else if (!i_stall) begin
      o_decode_valid       <= r_fetch_valid;
      o_decode_pc          <= r_pc;
      o_decode_instruction <= i_imem_data;
    end
  end

  sat_counter #(.WIDTH(16)) u_stall_count (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_inc     (i_stall && !i_branch_taken),
    .o_count   (o_stall_count)
  );

  sat_counter #(.WIDTH(16)) u_flush_count (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_inc     (i_branch_taken),
    .o_count   (o_flush_count)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations plus randomized stall/branch traffic against a behavioural model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [15:0] RV = 16'h0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, rst2_n = 1'b0, sat_rst_n = 1'b0;
  logic        stall = 1'b0, br = 1'b0;
  logic [15:0] tgt = '0;

  logic [15:0] imem_addr, imem_data = '0, dpc, dinst, sc, fc;
  logic        dv;
  logic [15:0] imem_addr2, imem_data2 = '0, dpc2, dinst2, sc2, fc2;
  logic        dv2;
  logic        sat_inc = 1'b0;
  logic [3:0]  sat_q;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .o_imem_addr(imem_addr), .i_imem_data(imem_data),
    .i_stall(stall), .i_branch_taken(br), .i_branch_target(tgt),
    .o_decode_valid(dv), .o_decode_pc(dpc), .o_decode_instruction(dinst),
    .o_stall_count(sc), .o_flush_count(fc)
  );

  fetch_stage #(.RESET_VECTOR(16'hFFFE)) dut2 (
    .i_clk(clk), .i_reset_n(rst2_n),
    .o_imem_addr(imem_addr2), .i_imem_data(imem_data2),
    .i_stall(1'b0), .i_branch_taken(1'b0), .i_branch_target(16'h0000),
    .o_decode_valid(dv2), .o_decode_pc(dpc2), .o_decode_instruction(dinst2),
    .o_stall_count(sc2), .o_flush_count(fc2)
  );

  sat_counter #(.WIDTH(4)) u_sat4 (
    .i_clk(clk), .i_reset_n(sat_rst_n), .i_inc(sat_inc), .o_count(sat_q)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  // Synchronous instruction memories: data for an address one cycle later.
  always @(posedge clk) begin
    imem_data  <= mem_word(imem_addr);
    imem_data2 <= mem_word(imem_addr2);
  end

  // Behavioural model state.
  logic [15:0] m_pc, m_dpc, m_dinst;
  logic        m_fv, m_dv;
  int          m_sc, m_fc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_fv = 1'b0; m_dv = 1'b0; m_dpc = '0; m_dinst = '0;
    m_sc = 0; m_fc = 0;
  endtask

  function automatic logic [15:0] m_next();
    if (!rst_n)              return RV;
    if (br)                  return tgt;
    if (!m_fv || stall)      return m_pc;
    return m_pc + 16'd1;
  endfunction

  task automatic model_clock();
    logic [15:0] nx;
    nx = m_next();
    if (br) begin
      m_dv = 1'b0;
    end else if (!stall) begin
      m_dv = m_fv; m_dpc = m_pc; m_dinst = mem_word(m_pc);
    end
    if (br)         m_fc = (m_fc < 65535) ? m_fc + 1 : 65535;
    else if (stall) m_sc = (m_sc < 65535) ? m_sc + 1 : 65535;
    m_pc = nx;
    m_fv = 1'b1;
  endtask

  task automatic compare_regs();
    check("decode_valid", {31'b0, dv}, {31'b0, m_dv});
    check("decode_pc", {16'b0, dpc}, {16'b0, m_dpc});
    check("decode_instruction", {16'b0, dinst}, {16'b0, m_dinst});
    check("stall_count", {16'b0, sc}, m_sc);
    check("flush_count", {16'b0, fc}, m_fc);
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step(input logic s, input logic b, input logic [15:0] t);
    stall = s; br = b; tgt = t;
    #1 check("imem_addr", {16'b0, imem_addr}, {16'b0, m_next()});
    @(posedge clk);
    if (rst_n) model_clock();
    @(negedge clk);
    compare_regs();
  endtask

  // Assert reset between edges and check outputs clear without a clock.
  task automatic mid_reset();
    stall = 1'b0; br = 1'b0;
    @(posedge clk);
    model_clock();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare_regs();
    check("reset_imem_addr", {16'b0, imem_addr}, {16'b0, RV});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_regs();
    check("rst_addr", {16'b0, imem_addr}, 32'h0000);
    check("rst_addr2", {16'b0, imem_addr2}, 32'hFFFE);
    check("rst_valid2", {31'b0, dv2}, 32'd0);

    rst_n = 1'b1; rst2_n = 1'b1; sat_rst_n = 1'b1;

    // Reset release: first valid decode two clocks after release.
    step(0, 0, 0);
    check("first_edge_valid", {31'b0, dv}, 32'd0);
    check("first_edge_valid2", {31'b0, dv2}, 32'd0);
    step(0, 0, 0);
    check("first_valid", {31'b0, dv}, 32'd1);
    check("first_pc", {16'b0, dpc}, 32'h0000);
    check("first_instr", {16'b0, dinst}, 32'hA000);
    check("rv_pc0", {16'b0, dpc2}, 32'hFFFE);
    check("rv_instr0", {16'b0, dinst2}, 32'h9FFE);
    check("rv_valid0", {31'b0, dv2}, 32'd1);
    step(0, 0, 0);
    check("second_pc", {16'b0, dpc}, 32'h0001);
    check("second_instr", {16'b0, dinst}, 32'hA001);
    check("rv_pc1", {16'b0, dpc2}, 32'hFFFF);
    step(0, 0, 0);
    check("rv_pc2", {16'b0, dpc2}, 32'h0000);
    step(0, 0, 0);
    check("rv_pc3", {16'b0, dpc2}, 32'h0001);
    check("rv_instr3", {16'b0, dinst2}, 32'hA001);
    repeat (2) step(0, 0, 0);
    check("pre_stall_pc", {16'b0, dpc}, 32'h0005);

    // Three stall cycles hold decode at pc 5, fetch address at 6.
    repeat (3) step(1, 0, 0);
    check("stall_hold_pc", {16'b0, dpc}, 32'h0005);
    check("stall_hold_addr", {16'b0, imem_addr}, 32'h0006);
    check("stall_count3", {16'b0, sc}, 32'd3);
    step(0, 0, 0);
    check("post_stall_pc", {16'b0, dpc}, 32'h0006);
    check("post_stall_instr", {16'b0, dinst}, 32'hA006);
    repeat (2) step(0, 0, 0);
    check("pre_branch_pc", {16'b0, dpc}, 32'h0008);

    // Branch squashes, target valid the following cycle.
    step(0, 1, 16'h0040);
    check("branch_squash", {31'b0, dv}, 32'd0);
    check("flush_count1", {16'b0, fc}, 32'd1);
    step(0, 0, 0);
    check("branch_target_pc", {16'b0, dpc}, 32'h0040);
    check("branch_target_valid", {31'b0, dv}, 32'd1);

    // Branch beats a simultaneous stall.
    step(1, 1, 16'h0100);
    check("sb_squash", {31'b0, dv}, 32'd0);
    check("sb_stall_count", {16'b0, sc}, 32'd3);
    step(0, 0, 0);
    check("sb_target_pc", {16'b0, dpc}, 32'h0100);
    check("sb_target_valid", {31'b0, dv}, 32'd1);

    // Asynchronous reset mid-stream.
    mid_reset();
    check("async_valid_drop", {31'b0, dv}, 32'd0);
    check("async_count_clear", {16'b0, fc}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) mid_reset();
      else step($urandom_range(3) == 0, $urandom_range(9) == 0, 16'($urandom));
    end

    // Long stall drives the stall counter into saturation.
    for (int i = 0; i < 65540; i++) step(1, 0, 0);
    check("stall_saturated", {16'b0, sc}, 32'h0000FFFF);
    step(0, 1, 16'hFFFF);
    step(0, 0, 0);
    step(0, 0, 0);
    check("wrap_pc", {16'b0, dpc}, 32'h0000);

    // Narrow saturating counter: counts then sticks at all-ones.
    sat_inc = 1'b1;
    repeat (3) @(negedge clk);
    check("sat4_count3", {28'b0, sat_q}, 32'd3);
    repeat (20) @(negedge clk);
    check("sat4_saturated", {28'b0, sat_q}, 32'd15);
    sat_inc = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
